// File: rtl/sync_align_fifo.sv
// In-order pairing FIFO: holds source pixels until the homography returns the warped colour.
// Optional build macro SYNC_ALIGN_MISMATCH_CHECK_EN enables the sticky coordinate-mismatch check.
module sync_align_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 10,
  parameter int unsigned RW    = 5,
  parameter int unsigned GW    = 6,
  parameter int unsigned BW    = 5
) (
  input  logic                     clk_25,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [CW-1:0]            in_x,
  input  logic [CW-1:0]            in_y,
  input  logic [RW-1:0]            in_r,
  input  logic [GW-1:0]            in_g,
  input  logic [BW-1:0]            in_b,
  output logic                     in_ready,
  output logic                     start,
  output logic [CW-1:0]            query_x,
  output logic [CW-1:0]            query_y,
  input  logic                     ret_valid,
  input  logic [CW-1:0]            ret_x,
  input  logic [CW-1:0]            ret_y,
  input  logic [RW-1:0]            ret_r,
  input  logic [GW-1:0]            ret_g,
  input  logic [BW-1:0]            ret_b,
  output logic                     val,
  output logic [CW-1:0]            sync_x,
  output logic [CW-1:0]            sync_y,
  output logic [RW-1:0]            dvi_r,
  output logic [GW-1:0]            dvi_g,
  output logic [BW-1:0]            dvi_b,
  output logic [RW-1:0]            ccd_r,
  output logic [GW-1:0]            ccd_g,
  output logic [BW-1:0]            ccd_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     mismatch,
  output logic                     underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = 2 * CW + RW + GW + BW;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} occ_t;

  occ_t          state, state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push, pop;
  logic [CW-1:0] head_x, head_y;
  logic [RW-1:0] head_r;
  logic [GW-1:0] head_g;
  logic [BW-1:0] head_b;

  assign in_ready = (state != FULL) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = ret_valid && (state != EMPTY) && !flush;
  assign {head_x, head_y, head_r, head_g, head_b} = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LW'(1);
        2'b01:   level_nxt = level - LW'(1);
        default: level_nxt = level;
      endcase
    end
    if (level_nxt == '0)
      state_nxt = EMPTY;
    else if (level_nxt == LW'(DEPTH))
      state_nxt = FULL;
    else
      state_nxt = ACTIVE;
  end

  // Storage carries no reset; occupancy tracking makes stale contents unreachable.
  always_ff @(posedge clk_25) begin
    if (push)
      mem[wr_ptr] <= {in_x, in_y, in_r, in_g, in_b};
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state     <= EMPTY;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      start     <= 1'b0;
      query_x   <= '0;
      query_y   <= '0;
      val       <= 1'b0;
      sync_x    <= '0;
      sync_y    <= '0;
      dvi_r     <= '0;
      dvi_g     <= '0;
      dvi_b     <= '0;
      ccd_r     <= '0;
      ccd_g     <= '0;
      ccd_b     <= '0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      start <= push;
      val   <= pop;
      if (ret_valid && state == EMPTY)
        underflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          query_x <= in_x;
          query_y <= in_y;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          sync_x <= head_x;
          sync_y <= head_y;
          dvi_r  <= head_r;
          dvi_g  <= head_g;
          dvi_b  <= head_b;
          ccd_r  <= ret_r;
          ccd_g  <= ret_g;
          ccd_b  <= ret_b;
        end
      end
    end
  end

`ifdef SYNC_ALIGN_MISMATCH_CHECK_EN
  always_ff @(posedge clk_25) begin
    if (rst)
      mismatch <= 1'b0;
    else if (pop && (ret_x != head_x || ret_y != head_y))
      mismatch <= 1'b1;
  end
`else
  logic unused_ret;
  assign unused_ret = ^{ret_x, ret_y};
  assign mismatch   = 1'b0;
`endif

endmodule
